// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default timing for the FIFO flush controller.
package fifo_ctrl_pkg;

   localparam int SYNC_STAGES        = 2;
   localparam int CNT_W              = 8;
   localparam int DEF_FLUSH_CYCLES   = 2;
   localparam int DEF_SETTLE_CYCLES  = SYNC_STAGES;
   localparam int DEF_DRAIN_TIMEOUT  = 255;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_FLUSH  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/fifo_flush_ctrl.sv
// FIFO flush sequencer: optional drain, timed flush pulse, synchronizer settle, done pulse.
//
//   state  | meaning
//   IDLE   | enables pass through, waiting for flush_req
//   DRAIN  | writes blocked, reads pass, wait for fifo_empty or timeout
//   FLUSH  | flush held for FLUSH_CYCLES, enables blocked
//   SETTLE | quiet for SETTLE_CYCLES so synchronizers clear
//   DONE   | one-cycle done pulse, back to IDLE
module fifo_flush_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES  = DEF_FLUSH_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
   input  logic clk_in,
   input  logic rst,
   input  logic flush_req,
   input  logic drain_mode,
   input  logic fifo_empty,
   input  logic wr_en_in,
   input  logic rd_en_in,
   output logic wr_en_out,
   output logic rd_en_out,
   output logic flush,
   output logic busy,
   output logic done,
   output logic timeout_err
);

   localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_e           state;
   state_e           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             timeout_hit;

   always_comb begin
      state_nxt   = state;
      timeout_hit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (flush_req) state_nxt = drain_mode ? ST_DRAIN : ST_FLUSH;
         end
         ST_DRAIN: begin
            // an empty FIFO in the last allowed cycle is a clean drain, not a timeout
            if (fifo_empty) begin
               state_nxt = ST_FLUSH;
            end else if (cnt >= DRAIN_LAST) begin
               state_nxt   = ST_FLUSH;
               timeout_hit = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (cnt >= FLUSH_LAST) state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt >= SETTLE_LAST) state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) cnt <= '0;
         else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
   end

   assign busy        = (state != ST_IDLE);
   assign flush       = (state == ST_FLUSH);
   assign done        = (state == ST_DONE);
   assign timeout_err = timeout_hit;
   assign wr_en_out   = (state == ST_IDLE) & wr_en_in;
   assign rd_en_out   = ((state == ST_IDLE) | (state == ST_DRAIN)) & rd_en_in;

endmodule

// File: tb/tb_fifo_flush_ctrl.sv
// Randomized scoreboard bench for fifo_flush_ctrl; expected timelines are planned per sequence.
module tb_fifo_flush_ctrl;

   localparam int F = 2;
   localparam int S = 2;
   localparam int T = 8;

   logic clk_in = 1'b0;
   logic rst = 1'b1;
   logic flush_req = 1'b0;
   logic drain_mode = 1'b0;
   logic fifo_empty = 1'b0;
   logic wr_en_in = 1'b0;
   logic rd_en_in = 1'b0;
   logic wr_en_out, rd_en_out, flush, busy, done, timeout_err;

   logic [5:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   fifo_flush_ctrl #(
      .FLUSH_CYCLES (F),
      .SETTLE_CYCLES(S),
      .DRAIN_TIMEOUT(T)
   ) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .flush_req  (flush_req),
      .drain_mode (drain_mode),
      .fifo_empty (fifo_empty),
      .wr_en_in   (wr_en_in),
      .rd_en_in   (rd_en_in),
      .wr_en_out  (wr_en_out),
      .rd_en_out  (rd_en_out),
      .flush      (flush),
      .busy       (busy),
      .done       (done),
      .timeout_err(timeout_err)
   );

   always #5 clk_in = ~clk_in;

   // mode: 0 = passthrough, 1 = reads only, 2 = both blocked
   task automatic step(input logic r, input logic req, input logic dm, input logic emp,
                       input int mode, input logic fl, input logic bs, input logic dn,
                       input logic te);
      logic w, rd, ew, er;
      @(posedge clk_in);
      #1;
      w  = 1'($urandom);
      rd = 1'($urandom);
      rst = r; flush_req = req; drain_mode = dm; fifo_empty = emp;
      wr_en_in = w; rd_en_in = rd;
      ew = (mode == 0) ? w : 1'b0;
      er = (mode == 2) ? 1'b0 : rd;
      exp_q.push_back({ew, er, fl, bs, dn, te});
   endtask

   // One flush sequence: idle gap, request, optional drain of d non-empty cycles, flush,
   // settle, done. rst_at >= 0 aborts with reset at that index after the drain phase.
   task automatic run_seq(input logic dm, input int d, input int rst_at);
      int gap, dc;
      logic te;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
         step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, dm, 1'($urandom), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (dm) begin
         dc = (d + 1 < T) ? d + 1 : T;
         for (int i = 0; i < dc; i++) begin
            te = (d >= T) && (i == T - 1);
            step(1'b0, 1'($urandom), 1'($urandom), (i == d), 1, 1'b0, 1'b1, 1'b0, te);
         end
      end
      for (int k = 0; k <= F + S; k++) begin
         step((k == rst_at), 1'($urandom), 1'($urandom), 1'($urandom), 2,
              (k < F), 1'b1, (k == F + S), 1'b0);
         if (k == rst_at) return;
      end
   endtask

   initial begin : monitor
      logic [5:0] e, act;
      forever begin
         @(negedge clk_in);
         cyc++;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {wr_en_out, rd_en_out, flush, busy, done, timeout_err};
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL outputs cycle %0d {wr,rd,flush,busy,done,terr} got %b expected %b",
                        cyc, act, e);
            end
         end
      end
   end

   initial begin : stim
      int guard;
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_seq(1'b0, 0, -1);
      run_seq(1'b1, 5, -1);
      run_seq(1'b1, T, -1);
      run_seq(1'b1, T - 1, -1);
      run_seq(1'b1, 0, -1);
      run_seq(1'b0, 0, 1);
      run_seq(1'b1, 2, F + 1);
      run_seq(1'b0, 0, F + S);
      for (int n = 0; n < 120; n++)
         run_seq(1'($urandom), $urandom_range(0, T + 3),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(0, F + S) : -1);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(negedge clk_in);
         guard++;
      end
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_queue pending %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
